// File: rtl/sign_mult_pkg.sv
// Purpose: shared widths, operand/product/id types and small helpers for the
//          shared signed-multiplier block.
// Contents: W/PW defaults, ID_W, operand_t, product_t, id_t, other_id().
package sign_mult_pkg;

    localparam int W    = 8;
    localparam int PW   = 2 * W;
    localparam int ID_W = 1;

    typedef logic signed [W-1:0]  operand_t;
    typedef logic signed [PW-1:0] product_t;
    typedef logic [ID_W-1:0]      id_t;

    // With two requesters the "next in line" is simply the other one.
    function automatic id_t other_id(input id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/sign_mult_core.sv
// Purpose: combinational two's-complement W x W -> PW multiplier.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
// Ports: a, b  - signed operands (W bits)
//        z     - signed product, sign-extended to PW bits
module sign_mult_core #(
    parameter int W  = 8,
    parameter int PW = 2 * W
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [PW-1:0] z
);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;

    // Sign-extend both operands to the product width first, so the multiply
    // is a plain PW x PW -> PW operation with no width mixing. With PW = 2*W
    // the low PW bits of the extended product are the exact signed product,
    // so -128 * -128 correctly yields +16384.
    assign a_ext = {{(PW-W){a[W-1]}}, a};
    assign b_ext = {{(PW-W){b[W-1]}}, b};
    assign prod  = a_ext * b_ext;
    assign z     = prod;

endmodule

// File: rtl/sign_mult_arbiter.sv
// Purpose: round-robin share of one signed multiplier between two requesters.
// Latency: operands accepted at edge N are presented on out_* after edge N+1.
// Backpressure: out_ready low stalls S2, then S1; both in*_ready drop when full.
// Ports: clk, rst (sync, active high)
//        in0_valid/in0_ready/in0_a/in0_b - requester 0 operand handshake
//        in1_valid/in1_ready/in1_a/in1_b - requester 1 operand handshake
//        out_valid/out_ready/out_z/out_id - product result handshake with id
module sign_mult_arbiter #(
    parameter int W  = sign_mult_pkg::W,
    parameter int PW = sign_mult_pkg::PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [W-1:0]  in0_a,
    input  logic [W-1:0]  in0_b,
    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [W-1:0]  in1_a,
    input  logic [W-1:0]  in1_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_z,
    output logic          out_id
);

    import sign_mult_pkg::*;

    // Round-robin pointer: requester that wins when both are valid.
    id_t           rr;

    // Stage 1: operand register.
    logic          s1_full;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;
    id_t           s1_id;

    // Stage 2: result register, drives out_* directly.
    logic          s2_full;
    logic [PW-1:0] s2_z;
    id_t           s2_id;

    logic          s1_adv;
    logic          s2_adv;
    logic          grant0;
    logic          grant1;
    logic          acc0;
    logic          acc1;
    logic          acc_any;
    id_t           acc_id;
    logic [W-1:0]  acc_a;
    logic [W-1:0]  acc_b;
    logic [PW-1:0] core_z;

    // A stage may take new data if it is empty or if its contents leave on
    // this same edge; this lets the pipe run at one result per cycle.
    assign s2_adv = !s2_full || out_ready;
    assign s1_adv = !s1_full || s2_adv;

    // Grant: a lone valid requester always wins; a tie goes to rr.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (in0_valid && in1_valid) begin
            grant0 = (rr == 1'b0);
            grant1 = (rr == 1'b1);
        end else begin
            grant0 = in0_valid;
            grant1 = in1_valid;
        end
    end

    // Readies are held low throughout reset so nothing is lost on the edge
    // that clears the pipeline.
    assign in0_ready = grant0 && s1_adv && !rst;
    assign in1_ready = grant1 && s1_adv && !rst;

    assign acc0    = in0_valid && in0_ready;
    assign acc1    = in1_valid && in1_ready;
    assign acc_any = acc0 || acc1;
    assign acc_id  = acc1 ? 1'b1 : 1'b0;
    assign acc_a   = acc1 ? in1_a : in0_a;
    assign acc_b   = acc1 ? in1_b : in0_b;

    sign_mult_core #(
        .W  (W),
        .PW (PW)
    ) u_core (
        .a (s1_a),
        .b (s1_b),
        .z (core_z)
    );

    // Pointer moves to the other requester only on a real transfer, so idle
    // or refused requests never disturb fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (acc_any) begin
            rr <= other_id(acc_id);
        end
    end

    // Stage 1. When S1 advances it either loads a new accept or empties
    // (its old contents, if any, are moving to S2 on this edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_id   <= '0;
        end else if (s1_adv) begin
            s1_full <= acc_any;
            if (acc_any) begin
                s1_a  <= acc_a;
                s1_b  <= acc_b;
                s1_id <= acc_id;
            end
        end
    end

    // Stage 2. Data is only captured from a full S1, so out_z/out_id keep the
    // last result while out_valid is low and never change during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_full <= 1'b0;
            s2_z    <= '0;
            s2_id   <= '0;
        end else if (s2_adv) begin
            s2_full <= s1_full;
            if (s1_full) begin
                s2_z  <= core_z;
                s2_id <= s1_id;
            end
        end
    end

    assign out_valid = s2_full;
    assign out_z     = s2_z;
    assign out_id    = s2_id;

endmodule

// File: tb/tb_sign_mult_arbiter.sv
module tb_sign_mult_arbiter;

    logic        clk;
    logic        rst;
    logic        in0_valid;
    logic        in0_ready;
    logic [7:0]  in0_a;
    logic [7:0]  in0_b;
    logic        in1_valid;
    logic        in1_ready;
    logic [7:0]  in1_a;
    logic [7:0]  in1_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic        out_id;

    sign_mult_arbiter #(.W(8), .PW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_a     (in0_a),
        .in0_b     (in0_b),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_a     (in1_a),
        .in1_b     (in1_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] z;
    } vec_t;

    typedef struct {
        logic        id;
        logic [15:0] z;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;

    vec_t tbl[10];
    exp_t exp_q[$];

    // Requester stream state for the scoreboard-driven tests.
    bit          pend[2];
    logic [7:0]  op_a[2];
    logic [7:0]  op_b[2];
    int          occ;
    logic        model_rr;
    bit          held;
    logic [15:0] held_z;
    logic        held_id;
    int          acc_count;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        int p;
        ia = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        ib = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        p  = ia * ib;
        return p[15:0];
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        pend[0]   = 1'b0;
        pend[1]   = 1'b0;
        exp_q.delete();
        occ       = 0;
        model_rr  = 1'b0;
        held      = 1'b0;
        acc_count = 0;
    endtask

    // Single isolated transaction from one requester, with exact latency checks.
    task automatic send_one(input int id, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] ez, input string nm);
        int n;
        out_ready = 1'b1;
        if (id == 0) begin
            in0_valid = 1'b1; in0_a = a; in0_b = b;
        end else begin
            in1_valid = 1'b1; in1_a = a; in1_b = b;
        end
        #1;
        n = 0;
        while (!((id == 0) ? in0_ready : in1_ready) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_rdy"}, (id == 0) ? in0_ready : in1_ready, 1);
        check({nm, "_other_rdy"}, (id == 0) ? in1_ready : in0_ready, 0);
        @(posedge clk); #1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        check({nm, "_lat1_vld"}, out_valid, 0);
        check({nm, "_lat1_other_rdy"}, (id == 0) ? in1_ready : in0_ready, 0);
        @(posedge clk); #1;
        check({nm, "_vld"}, out_valid, 1);
        check({nm, "_z"}, out_z, ez);
        check({nm, "_id"}, out_id, id);
        @(posedge clk); #1;
    endtask

    // One clock of streaming traffic checked against the occupancy and
    // round-robin model plus the in-order result scoreboard.
    task automatic step(input bit oready);
        bit   acc0;
        bit   acc1;
        exp_t e;
        in0_valid = pend[0]; in0_a = op_a[0]; in0_b = op_b[0];
        in1_valid = pend[1]; in1_a = op_a[1]; in1_b = op_b[1];
        out_ready = oready;
        #1;
        acc0 = in0_valid && in0_ready;
        acc1 = in1_valid && in1_ready;
        check("ready_excl", in0_ready & in1_ready, 0);
        check("ready_any", in0_ready | in1_ready, (pend[0] | pend[1]) && (occ < 2 || oready));
        if (pend[0] && pend[1] && (acc0 || acc1))
            check("rr_grant", acc1, model_rr);
        if (held) begin
            check("hold_vld", out_valid, 1);
            check("hold_z", out_z, held_z);
            check("hold_id", out_id, held_id);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_z", out_z, e.z);
                check("sb_id", out_id, e.id);
            end
            occ--;
        end
        held    = out_valid && !out_ready;
        held_z  = out_z;
        held_id = out_id;
        if (acc0) begin
            e.id = 1'b0; e.z = ref_prod(op_a[0], op_b[0]);
            exp_q.push_back(e);
            pend[0] = 1'b0; model_rr = 1'b1; occ++; acc_count++;
        end
        if (acc1) begin
            e.id = 1'b1; e.z = ref_prod(op_a[1], op_b[1]);
            exp_q.push_back(e);
            pend[1] = 1'b0; model_rr = 1'b0; occ++; acc_count++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pend[0] || pend[1]) && n < 100) begin
            step(1'b1);
            n++;
        end
        check({nm, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{0, 8'h80, 8'h80, 16'h4000};  // -128 * -128
        tbl[1] = '{1, 8'h80, 8'h7F, 16'hC080};  // -128 *  127
        tbl[2] = '{0, 8'hFD, 8'hFE, 16'h0006};  //   -3 *   -2
        tbl[3] = '{1, 8'hFB, 8'h0C, 16'hFFC4};  //   -5 *   12
        tbl[4] = '{0, 8'h0A, 8'h02, 16'h0014};  //   10 *    2
        tbl[5] = '{1, 8'h0C, 8'h15, 16'h00FC};  //   12 *   21
        tbl[6] = '{0, 8'h7F, 8'h7F, 16'h3F01};  //  127 *  127
        tbl[7] = '{1, 8'h00, 8'h80, 16'h0000};  //    0 * -128
        tbl[8] = '{0, 8'hFF, 8'hFF, 16'h0001};  //   -1 *   -1
        tbl[9] = '{1, 8'hFF, 8'h7F, 16'hFF81};  //   -1 *  127

        in0_a = '0; in0_b = '0; in1_a = '0; in1_b = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        op_a[0] = '0; op_b[0] = '0; op_a[1] = '0; op_b[1] = '0;

        // Reset values, and readies forced low even with a valid request.
        rst = 1'b1; out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in0_rdy", in0_ready, 0);
        check("rst_in1_rdy", in1_ready, 0);
        check("rst_out_vld", out_valid, 0);
        check("rst_out_z", out_z, 0);
        check("rst_out_id", out_id, 0);
        in0_valid = 1'b0;
        rst = 1'b0;

        // First transaction: 10 * 2 from requester 0.
        send_one(0, 8'h0A, 8'h02, 16'd20, "basic");

        // Both valid and held: in0 first, then in1, results on consecutive cycles.
        do_reset();
        in0_valid = 1'b1; in0_a = 8'hF6; in0_b = 8'h02;
        in1_valid = 1'b1; in1_a = 8'hF4; in1_b = 8'hEB;
        #1;
        check("both_c0_rdy0", in0_ready, 1);
        check("both_c0_rdy1", in1_ready, 0);
        @(posedge clk); #1;
        check("both_c1_rdy0", in0_ready, 0);
        check("both_c1_rdy1", in1_ready, 1);
        check("both_c1_vld", out_valid, 0);
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        check("both_r0_vld", out_valid, 1);
        check("both_r0_z", out_z, 16'hFFEC);
        check("both_r0_id", out_id, 0);
        @(posedge clk); #1;
        check("both_r1_vld", out_valid, 1);
        check("both_r1_z", out_z, 16'h00FC);
        check("both_r1_id", out_id, 1);
        @(posedge clk); #1;
        check("both_empty_vld", out_valid, 0);

        // Table of isolated products, including the extreme corners.
        for (int i = 0; i < 10; i++)
            send_one(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].z, $sformatf("tbl%0d", i));

        // Backpressure: consumer stalls 5 cycles while both requesters stream.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k]) begin
                    op_a[k] = 8'($urandom); op_b[k] = 8'($urandom); pend[k] = 1'b1;
                end
            end
            step(1'b0);
        end
        check("bp_accepts", acc_count, 2);
        check("bp_rdy_low", {in0_ready, in1_ready}, 0);
        drain("bp_drain");

        // Reset while S1 and S2 both hold data.
        do_reset();
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_a = 8'h05; in0_b = 8'h05;
        in1_valid = 1'b1; in1_a = 8'h06; in1_b = 8'h06;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_full_vld", out_valid, 1);
        check("mid_full_rdy", {in0_ready, in1_ready}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_vld", out_valid, 0);
        check("mid_rst_z", out_z, 0);
        check("mid_rst_id", out_id, 0);
        check("mid_rst_rdy", {in0_ready, in1_ready}, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rr0_rdy0", in0_ready, 1);
        check("mid_rr0_rdy1", in1_ready, 0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_idle_vld", out_valid, 0);
        send_one(1, 8'h0C, 8'h15, 16'd252, "mid_after");

        // Random valids and consumer readiness against the scoreboard.
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(1, 0) == 1) begin
                    op_a[k] = 8'($urandom); op_b[k] = 8'($urandom); pend[k] = 1'b1;
                end
            end
            step($urandom_range(9, 0) < 7);
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
